seven_seg_scan_ctrl: RTL and testbench

Multiplexing scan controller for the 4-digit common-anode 7-segment display on the FPGA board. It holds one segment byte per digit and time-multiplexes the shared segment bus across the digits, with a blanking guard between slots to suppress ghosting. The host (PIC32 parallel bus) writes digit bytes into a shadow bank and commits them atomically at a frame boundary, so updates never tear. It sits between the host-interface capture logic and the board pins in top.

---
 rtl/seven_seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 4..8 digit 7-segment scanner: blank guard then lit phase per slot, shadow bank committed at frame boundary.
// Outputs registered (change on the edge that enters each phase); host writes and commits are never back-pressured.
module seven_seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic [DIGITS-1:0] digit_mask,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] digit_n,
  output logic              frame_start,
  output logic              commit_pending
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t          state;
  logic            run;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [7:0]      shadow [DIGITS];
  logic [7:0]      active [DIGITS];
  logic [DIGITS-1:0] lit_n;
  logic            last_blank;
  logic            last_on;
  logic            boundary;

  assign last_blank = (state == BLANK) && (cnt == BLANK_LAST);
  assign last_on    = (state == ON) && (cnt == ON_LAST);
  assign boundary   = last_on && (idx == IDX_LAST);

  // Anode pattern for the current slot; the mask is sampled live every lit cycle.
  always_comb begin
    lit_n = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i) && digit_mask[i]) lit_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && wr_addr == 3'(i)) shadow[i] <= wr_data;
      end
      // A commit arriving in the boundary cycle itself re-arms for the next frame.
      if (boundary && commit_pending) begin
        for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
        commit_pending <= commit;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      run         <= 1'b0;
      seg         <= 8'h00;
      digit_n     <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!run) begin
        // First cycle after release opens slot 0 and flags the frame.
        run         <= 1'b1;
        frame_start <= 1'b1;
      end else begin
        case (state)
          BLANK: begin
            if (last_blank) begin
              state   <= ON;
              cnt     <= '0;
              seg     <= active[idx];
              digit_n <= lit_n;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ON: begin
            if (last_on) begin
              state   <= BLANK;
              cnt     <= '0;
              seg     <= 8'h00;
              digit_n <= '1;
              if (boundary) begin
                idx         <= '0;
                frame_start <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt     <= cnt + 1'b1;
              seg     <= active[idx];
              digit_n <= lit_n;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a position-based scan model (CLK_DIV=8, BLANK_CYCLES=2, DIGITS=4).
module tb_seven_seg_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       commit = 1'b0;
  logic [3:0] digit_mask = 4'hF;
  logic [7:0] seg;
  logic [3:0] digit_n;
  logic       frame_start;
  logic       commit_pending;

  int total = 0;
  int bad = 0;
  int k;
  logic [7:0] m_act [4];
  logic [7:0] m_sh  [4];
  logic       m_pend;
  logic [7:0] vals  [4];

  seven_seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .digit_mask(digit_mask), .seg(seg),
    .digit_n(digit_n), .frame_start(frame_start), .commit_pending(commit_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the cycle position within a 32-cycle frame.
  task automatic scan_check();
    int p, s, q;
    logic [7:0] eseg;
    logic [3:0] edn;
    p = k % 32;
    s = p / 8;
    q = p % 8;
    eseg = 8'h00;
    edn = 4'hF;
    if (q >= 2) begin
      eseg = m_act[s];
      if (digit_mask[s]) edn[s] = 1'b0;
    end
    chk($sformatf("frame_start k=%0d", k), 8'(frame_start), 8'(p == 0));
    chk($sformatf("seg k=%0d", k), seg, eseg);
    chk($sformatf("digit_n k=%0d", k), 8'(digit_n), 8'(edn));
    chk($sformatf("pending k=%0d", k), 8'(commit_pending), 8'(m_pend));
  endtask

  task automatic tick();
    if (k >= 0 && k % 32 == 31 && m_pend) begin
      m_act = m_sh;
      m_pend = commit;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (wr_en && wr_addr < 3'd4) m_sh[wr_addr[1:0]] = wr_data;
    @(posedge clock);
    #1;
    k++;
    scan_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int p);
    tick();
    while (k % 32 != p) tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 8'h00;
      m_sh[i]  = 8'h00;
    end
    m_pend = 1'b0;
    k = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vals[0] = 8'h3F; vals[1] = 8'h06; vals[2] = 8'h5B; vals[3] = 8'h4F;
    model_reset();

    // Reset values while held in reset
    #12;
    chk("rst seg", seg, 8'h00);
    chk("rst digit_n", 8'(digit_n), 8'h0F);
    chk("rst frame_start", 8'(frame_start), 8'h00);
    chk("rst pending", 8'(commit_pending), 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: blank scan, first frame pulse right after release
    tick();
    chk("t1 first frame_start", 8'(frame_start), 8'h01);
    run_to(2);
    chk("t1 slot0 on digit_n", 8'(digit_n), 8'h0E);
    run_to(26);
    chk("t1 slot3 on digit_n", 8'(digit_n), 8'h07);
    ticks(38);

    // 2: load digits, commit mid-frame
    wr_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wr_addr = 3'(a);
      wr_data = vals[a];
      tick();
    end
    wr_en = 1'b0;
    run_to(10);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t2 pending set", 8'(commit_pending), 8'h01);
    run_to(2);
    chk("t2 slot0 seg", seg, 8'h3F);
    run_to(10);
    chk("t2 slot1 seg", seg, 8'h06);
    run_to(18);
    chk("t2 slot2 seg", seg, 8'h5B);
    run_to(26);
    chk("t2 slot3 seg", seg, 8'h4F);
    run_to(8);
    chk("t2 blank seg", seg, 8'h00);

    // 3: shadow write without commit stays hidden; out-of-range write ignored
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
    tick();
    wr_addr = 3'd5; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    ticks(96);
    run_to(10);
    chk("t3 uncommitted slot1", seg, 8'h06);
    run_to(12);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_to(0);
    chk("t3 pending cleared", 8'(commit_pending), 8'h00);
    run_to(10);
    chk("t3 committed slot1", seg, 8'hFF);

    // 4: masked digits keep their slots dark
    run_to(0);
    digit_mask = 4'b1010;
    run_to(2);
    chk("t4 masked slot0 digit_n", 8'(digit_n), 8'h0F);
    run_to(10);
    chk("t4 lit slot1 digit_n", 8'(digit_n), 8'h0D);
    ticks(56);
    digit_mask = 4'hF;

    // 5: commit + write in the boundary cycle wait for the next boundary
    run_to(31);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    chk("t5 pending kept", 8'(commit_pending), 8'h01);
    run_to(2);
    chk("t5 slot0 not updated", seg, 8'h3F);
    run_to(0);
    run_to(2);
    chk("t5 slot0 updated", seg, 8'h77);
    run_to(18);
    chk("t5 slot2 out-of-range write ignored", seg, 8'h5B);

    // 6: async reset during slot 2 ON with a pending commit
    run_to(4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_to(20);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6 async seg", seg, 8'h00);
    chk("t6 async digit_n", 8'(digit_n), 8'h0F);
    chk("t6 async pending", 8'(commit_pending), 8'h00);
    model_reset();
    @(posedge clock);
    #2;
    chk("t6 held seg", seg, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("t6 restart frame_start", 8'(frame_start), 8'h01);
    run_to(2);
    chk("t6 restart slot0 digit_n", 8'(digit_n), 8'h0E);
    chk("t6 restart slot0 seg", seg, 8'h00);
    ticks(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
